// File: rtl/fifo_stream_adapter_pkg.sv
// fifo_stream_adapter_pkg
//   Helpers for the FIFO-to-stream adapter.
//   occ_next: buffered + in-flight occupancy after this cycle's pop, held in
//   3 bits so the read-issue compare sees the value before any truncation.
package fifo_stream_adapter_pkg;

  function automatic logic [2:0] occ_next(input logic [1:0] cnt,
                                          input logic       infl,
                                          input logic       pop);
    return {1'b0, cnt} + {2'b00, infl} - {2'b00, pop};
  endfunction

endpackage

// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter
//   Turns the read side of a non-FWFT synchronous FIFO (data one cycle after
//   rd_en) into a registered valid/ready stream. Reads are issued
//   speculatively and land in a 2-entry buffer, giving one word per cycle
//   when the consumer keeps ready high.
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   fifo_dout   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty  FIFO empty flag
//   fifo_rd_en  FIFO read strobe (combinational)
//   out_data    stream data, registered head of buffer
//   out_valid   stream valid, registered
//   out_ready   consumer ready
import fifo_stream_adapter_pkg::*;

module fifo_stream_adapter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int         CNT_W     = 2;
  localparam logic [2:0] RD_THRESH = 3'd1;

  logic [CNT_W-1:0] r_count;
  logic             r_inflight;
  logic             r_rd_ptr;
  logic             r_wr_ptr;
  logic [WIDTH-1:0] r_entry [2];
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;

  logic             w_pop;
  logic [2:0]       w_occ;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_rd_ptr_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_pop        = r_out_valid & out_ready;
  assign w_occ        = occ_next(r_count, r_inflight, w_pop);
  assign w_count_nxt  = w_occ[CNT_W-1:0];
  assign w_rd_ptr_nxt = r_rd_ptr ^ w_pop;

  // Issue a read only if the word it returns is guaranteed a free slot:
  // after this cycle's pop, buffered + in-flight must leave room for one.
  // w_occ cannot wrap negative: a pop implies count != 0.
  assign fifo_rd_en = ~rst & ~fifo_empty & (w_occ <= RD_THRESH);

  // Next head word: the landing word bypasses storage when it lands in the
  // slot that becomes the head (buffer empty, or drained by this pop).
  always_comb begin
    w_head_nxt = r_entry[w_rd_ptr_nxt];
    if (r_inflight && (r_wr_ptr == w_rd_ptr_nxt))
      w_head_nxt = fifo_dout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count     <= '0;
      r_inflight  <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_entry[0]  <= '0;
      r_entry[1]  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (r_inflight) begin
        r_entry[r_wr_ptr] <= fifo_dout;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_inflight  <= fifo_rd_en;
      r_out_valid <= (w_count_nxt != '0);
      r_out_data  <= w_head_nxt;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule
